// File: rtl/qam16_symbol_tx.sv
// 16-QAM transmit symbol source: symbol FIFO, 4-ASK I/Q mapper, priming FSM
// and zero-stuffed x4 upsampler feeding the pulse-shaping filter.
module qam16_symbol_tx #(
  parameter int                FIFO_DEPTH  = 8,
  parameter int                START_LEVEL = 4,
  parameter logic signed [17:0] A_LVL      = 18'sd21845
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic [3:0]         in_sym,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [17:0] sym_i,
  output logic signed [17:0] sym_q,
  output logic signed [17:0] up_i,
  output logic signed [17:0] up_q,
  output logic               active,
  output logic               underflow,
  output logic [15:0]        underflow_cnt,
  output logic [31:0]        sym_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] START_CNT = (AW+1)'(START_LEVEL);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [17:0] L1 = A_LVL;
  localparam logic signed [17:0] L3 = 18'(A_LVL * 18'sd3);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STARVED = 2'd2} state_t;

  function automatic logic signed [17:0] map_lvl(input logic [1:0] bits);
    case (bits)
      2'b00:   map_lvl = -L3;
      2'b01:   map_lvl = -L1;
      2'b10:   map_lvl = L1;
      2'b11:   map_lvl = L3;
      default: map_lvl = 18'sd0;
    endcase
  endfunction

  logic [3:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        occ_q, occ_d;
  logic               in_ready_q;
  state_t             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic signed [17:0] sym_i_q, sym_q_q, up_i_q, up_q_q;
  logic               active_q, underflow_q;
  logic [15:0]        underflow_cnt_q;
  logic [31:0]        sym_cnt_q;

  logic               wr_s, pop_s, uf_s;
  logic [3:0]         head_s;
  logic signed [17:0] lvl_i_s, lvl_q_s;

  assign wr_s   = in_valid & in_ready_q;
  assign head_s = mem_q[rd_ptr_q];

  // Pop/underflow decision and next-state logic at each symbol enable
  always_comb begin
    pop_s   = 1'b0;
    uf_s    = 1'b0;
    state_d = state_q;
    if (sym_clk_en) begin
      case (state_q)
        RUN: begin
          if (occ_q != {(AW+1){1'b0}}) begin
            pop_s = 1'b1;
          end else begin
            uf_s    = 1'b1;
            state_d = STARVED;
          end
        end
        IDLE, STARVED: begin
          if (occ_q >= START_CNT) begin
            pop_s   = 1'b1;
            state_d = RUN;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Occupancy, sample phase and mapped levels for the entry being popped
  always_comb begin
    occ_d = occ_q + (AW+1)'(wr_s) - (AW+1)'(pop_s);
    if (sym_clk_en) begin
      phase_d = 2'd0;
    end else if (sam_clk_en) begin
      phase_d = phase_q + 2'd1;
    end else begin
      phase_d = phase_q;
    end
    if (pop_s) begin
      lvl_i_s = map_lvl(head_s[1:0]);
      lvl_q_s = map_lvl(head_s[3:2]);
    end else begin
      lvl_i_s = 18'sd0;
      lvl_q_s = 18'sd0;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge sys_clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= in_sym;
    end
  end

  // FSM, pointers and all registered outputs
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q        <= {AW{1'b0}};
      rd_ptr_q        <= {AW{1'b0}};
      occ_q           <= {(AW+1){1'b0}};
      in_ready_q      <= 1'b1;
      state_q         <= IDLE;
      phase_q         <= 2'd0;
      sym_i_q         <= 18'sd0;
      sym_q_q         <= 18'sd0;
      up_i_q          <= 18'sd0;
      up_q_q          <= 18'sd0;
      active_q        <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= 16'd0;
      sym_cnt_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      in_ready_q <= (occ_d != FULL_CNT);
      phase_q    <= phase_d;
      active_q   <= (state_d == RUN);
      underflow_q <= uf_s;
      if (wr_s) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        sym_cnt_q <= sym_cnt_q + 32'd1;
      end
      if (uf_s && (underflow_cnt_q != 16'hFFFF)) begin
        underflow_cnt_q <= underflow_cnt_q + 16'd1;
      end
      // Phase 0 carries the level; the other three sample phases are zero-stuffed
      if (sym_clk_en) begin
        sym_i_q <= lvl_i_s;
        sym_q_q <= lvl_q_s;
        up_i_q  <= lvl_i_s;
        up_q_q  <= lvl_q_s;
      end else if (sam_clk_en && (phase_d != 2'd0)) begin
        up_i_q <= 18'sd0;
        up_q_q <= 18'sd0;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign sym_i         = sym_i_q;
  assign sym_q         = sym_q_q;
  assign up_i          = up_i_q;
  assign up_q          = up_q_q;
  assign active        = active_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = underflow_cnt_q;
  assign sym_cnt       = sym_cnt_q;

endmodule

// File: tb/tb_qam16_symbol_tx.sv
// Directed self-checking bench for qam16_symbol_tx with hand-computed levels.
module tb_qam16_symbol_tx;

  logic               sys_clk = 1'b0;
  logic               reset = 1'b1;
  logic               sam_clk_en = 1'b0;
  logic               sym_clk_en = 1'b0;
  logic [3:0]         in_sym = 4'd0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] sym_i, sym_q, up_i, up_q;
  logic               active, underflow;
  logic [15:0]        underflow_cnt;
  logic [31:0]        sym_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  qam16_symbol_tx dut (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .in_sym(in_sym), .in_valid(in_valid), .in_ready(in_ready),
    .sym_i(sym_i), .sym_q(sym_q), .up_i(up_i), .up_q(up_q),
    .active(active), .underflow(underflow), .underflow_cnt(underflow_cnt), .sym_cnt(sym_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Hand table of the 4-ASK levels for A_LVL = 21845
  function automatic logic signed [17:0] lvl(input logic [1:0] b);
    case (b)
      2'b00:   lvl = -18'sd65535;
      2'b01:   lvl = -18'sd21845;
      2'b10:   lvl = 18'sd21845;
      2'b11:   lvl = 18'sd65535;
      default: lvl = 18'sd0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d);
    in_sym   = d;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic tick(input logic s);
    sam_clk_en = 1'b1;
    sym_clk_en = s;
    cyc();
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
  endtask

  task automatic pad3();
    repeat (3) tick(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cyc();
    n_checks++;
    if (in_ready !== 1'b1 || active !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b act=%b uf=%b expected 1 0 0", in_ready, active, underflow);
    end
    n_checks++;
    if (sym_i !== 18'sd0 || sym_q !== 18'sd0 || up_i !== 18'sd0 || up_q !== 18'sd0) begin
      n_fail++;
      $display("FAIL reset_levels: got %0d %0d %0d %0d expected all 0", sym_i, sym_q, up_i, up_q);
    end
    n_checks++;
    if (sym_cnt !== 32'd0 || underflow_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got sym_cnt=%0d uf_cnt=%0d expected 0 0", sym_cnt, underflow_cnt);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_mapping();
    logic signed [17:0] exp_l [4];
    exp_l[0] = -18'sd65535; exp_l[1] = -18'sd21845; exp_l[2] = 18'sd21845; exp_l[3] = 18'sd65535;
    wr(4'h0); wr(4'h5); wr(4'hA); wr(4'hF);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1);
      n_checks++;
      if (active !== 1'b1) begin
        n_fail++;
        $display("FAIL map_active[%0d]: got %b expected 1", k, active);
      end
      n_checks++;
      if (sym_i !== exp_l[k] || sym_q !== exp_l[k] || up_i !== exp_l[k] || up_q !== exp_l[k]) begin
        n_fail++;
        $display("FAIL map_level[%0d]: got sym %0d/%0d up %0d/%0d expected %0d", k, sym_i, sym_q, up_i, up_q, exp_l[k]);
      end
      for (int p = 1; p < 4; p++) begin
        tick(1'b0);
        n_checks++;
        if (up_i !== 18'sd0 || up_q !== 18'sd0 || sym_i !== exp_l[k]) begin
          n_fail++;
          $display("FAIL map_stuff[%0d.%0d]: got up %0d/%0d sym_i %0d expected 0/0 %0d", k, p, up_i, up_q, sym_i, exp_l[k]);
        end
      end
    end
    n_checks++;
    if (sym_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL map_sym_cnt: got %0d expected 4", sym_cnt);
    end
  endtask

  task automatic test_mixed_iq();
    wr(4'h6);
    tick(1'b1);
    n_checks++;
    if (sym_i !== 18'sd21845 || sym_q !== -18'sd21845 || sym_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL mixed_iq: got %0d/%0d cnt %0d expected 21845/-21845 cnt 5", sym_i, sym_q, sym_cnt);
    end
    pad3();
  endtask

  task automatic test_underflow();
    tick(1'b1);
    n_checks++;
    if (underflow !== 1'b1 || underflow_cnt !== 16'd1 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_pulse: got uf=%b cnt=%0d act=%b expected 1 1 0", underflow, underflow_cnt, active);
    end
    n_checks++;
    if (sym_i !== 18'sd0 || up_i !== 18'sd0 || sym_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL uf_zero: got sym_i=%0d up_i=%0d cnt=%0d expected 0 0 5", sym_i, up_i, sym_cnt);
    end
    pad3();
    n_checks++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_one_cycle: got %b expected 0", underflow);
    end
    tick(1'b1);
    n_checks++;
    if (underflow !== 1'b0 || underflow_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL uf_no_repulse: got uf=%b cnt=%0d expected 0 1", underflow, underflow_cnt);
    end
    pad3();
    wr(4'h3); wr(4'hC); wr(4'h9);
    tick(1'b1);
    n_checks++;
    if (active !== 1'b0 || sym_i !== 18'sd0) begin
      n_fail++;
      $display("FAIL starved_hold: got act=%b sym_i=%0d expected 0 0", active, sym_i);
    end
    pad3();
    wr(4'h0);
    tick(1'b1);
    n_checks++;
    if (active !== 1'b1 || sym_i !== 18'sd65535 || sym_q !== -18'sd65535 || sym_cnt !== 32'd6) begin
      n_fail++;
      $display("FAIL restart: got act=%b %0d/%0d cnt %0d expected 1 65535/-65535 cnt 6", active, sym_i, sym_q, sym_cnt);
    end
    pad3();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [4];
    exp_d[0] = 4'h9; exp_d[1] = 4'h0; exp_d[2] = 4'h5; exp_d[3] = 4'hA;
    wr(4'h5);
    in_sym = 4'hA; in_valid = 1'b1; sam_clk_en = 1'b1; sym_clk_en = 1'b1;
    cyc();
    in_valid = 1'b0; sam_clk_en = 1'b0; sym_clk_en = 1'b0;
    n_checks++;
    if (sym_i !== -18'sd65535 || sym_q !== 18'sd65535 || in_ready !== 1'b1 || sym_cnt !== 32'd7) begin
      n_fail++;
      $display("FAIL b2b_pop: got %0d/%0d rdy=%b cnt=%0d expected -65535/65535 1 7", sym_i, sym_q, in_ready, sym_cnt);
    end
    pad3();
    for (int k = 0; k < 4; k++) begin
      tick(1'b1);
      n_checks++;
      if (sym_i !== lvl(exp_d[k][1:0]) || sym_q !== lvl(exp_d[k][3:2])) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: got %0d/%0d expected %0d/%0d", k, sym_i, sym_q, lvl(exp_d[k][1:0]), lvl(exp_d[k][3:2]));
      end
      pad3();
    end
    tick(1'b1);
    n_checks++;
    if (underflow !== 1'b1 || underflow_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_occupancy: got uf=%b cnt=%0d expected 1 2", underflow, underflow_cnt);
    end
    pad3();
  endtask

  task automatic test_full();
    logic [3:0] d;
    for (int k = 1; k <= 8; k++) begin
      wr(4'(k));
      if (k == 7) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_7: got in_ready=%b expected 1", in_ready);
        end
      end
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_8: got in_ready=%b expected 0", in_ready);
    end
    in_sym = 4'hE; in_valid = 1'b1;
    cyc();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_hold: got in_ready=%b expected 0", in_ready);
    end
    sam_clk_en = 1'b1; sym_clk_en = 1'b1;
    cyc();
    sam_clk_en = 1'b0; sym_clk_en = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || active !== 1'b1 || sym_i !== -18'sd21845) begin
      n_fail++;
      $display("FAIL full_pop: got rdy=%b act=%b sym_i=%0d expected 1 1 -21845", in_ready, active, sym_i);
    end
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_refill: got in_ready=%b expected 0", in_ready);
    end
    pad3();
    for (int k = 0; k < 8; k++) begin
      d = (k == 7) ? 4'hE : 4'(k + 2);
      tick(1'b1);
      n_checks++;
      if (sym_i !== lvl(d[1:0]) || sym_q !== lvl(d[3:2])) begin
        n_fail++;
        $display("FAIL full_order[%0d]: got %0d/%0d expected %0d/%0d", k, sym_i, sym_q, lvl(d[1:0]), lvl(d[3:2]));
      end
      pad3();
    end
  endtask

  task automatic test_reset_midstream();
    wr(4'h1); wr(4'h2); wr(4'h3); wr(4'h4); wr(4'h5);
    tick(1'b1);
    pad3();
    wr(4'h6);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (sym_i !== 18'sd0 || sym_q !== 18'sd0 || up_i !== 18'sd0 || active !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_out: got %0d/%0d up %0d act=%b rdy=%b expected 0/0 0 0 1", sym_i, sym_q, up_i, active, in_ready);
    end
    n_checks++;
    if (sym_cnt !== 32'd0 || underflow_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_cnt: got %0d %0d expected 0 0", sym_cnt, underflow_cnt);
    end
    cyc();
    reset = 1'b0;
    wr(4'h7); wr(4'h8); wr(4'h9);
    tick(1'b1);
    n_checks++;
    if (active !== 1'b0 || sym_i !== 18'sd0) begin
      n_fail++;
      $display("FAIL midrst_prime: got act=%b sym_i=%0d expected 0 0", active, sym_i);
    end
    pad3();
    wr(4'hA);
    tick(1'b1);
    n_checks++;
    if (active !== 1'b1 || sym_i !== 18'sd65535 || sym_q !== -18'sd21845 || sym_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL midrst_restart: got act=%b %0d/%0d cnt %0d expected 1 65535/-21845 cnt 1", active, sym_i, sym_q, sym_cnt);
    end
    pad3();
  endtask

  initial begin
    test_reset();
    test_mapping();
    test_mixed_iq();
    test_underflow();
    test_back_to_back();
    test_full();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qam16_symbol_tx.md
Name: qam16_symbol_tx

Overview:
- Transmit-side symbol source for the 16-QAM MER test chain; the counterpart of the slicer/decision path.
- Accepts 4-bit symbols over a valid/ready handshake, buffers them in a FIFO, and maps each to I and Q 4-ASK levels in 1s17 format.
- Releases one symbol per sym_clk_en and produces zero-stuffed x4 upsampled I/Q samples on sam_clk_en, feeding the pulse-shaping filter and DUT.
- Reports FIFO underflow and the running symbol count.

Parameters:
- FIFO_DEPTH, 8, symbol FIFO entries; power of two, minimum 4.
- START_LEVEL, 4, FIFO occupancy required to leave IDLE.
- A_LVL, 18'sd21845, inner 4-ASK level magnitude in 1s17; the outer level is 3*A_LVL.

Ports:
- sys_clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- sam_clk_en, in, 1, sample-rate enable, one sys_clk wide.
- sym_clk_en, in, 1, symbol-rate enable; always coincident with a sam_clk_en, every 4th one.
- in_sym, in, 4, symbol bits; [1:0] are I, [3:2] are Q.
- in_valid, in, 1, in_sym is valid.
- in_ready, out, 1, FIFO can accept a symbol.
- sym_i, out, 18, signed I symbol level held for one symbol period.
- sym_q, out, 18, signed Q symbol level held for one symbol period.
- up_i, out, 18, signed I upsampled sample.
- up_q, out, 18, signed Q upsampled sample.
- active, out, 1, state is RUN.
- underflow, out, 1, one-cycle pulse on underflow.
- underflow_cnt, out, 16, saturating count of underflows.
- sym_cnt, out, 32, symbols transmitted; wraps.

Behaviour:
- Reset (async, active-high) values:
  - FIFO empty, in_ready=1.
  - All level/sample outputs 0; active=0; underflow=0; underflow_cnt=0; sym_cnt=0.
  - state=IDLE; sample phase counter=0.
- Mapping, per 2-bit field: 00->-3*A_LVL, 01->-A_LVL, 10->+A_LVL, 11->+3*A_LVL. Levels are computed at full width with no saturation; A_LVL is constrained so that 3*A_LVL <= 131071.
- Write side:
  - A write occurs on a posedge with in_valid&&in_ready.
  - in_ready = !full, registered so it reflects occupancy after the current cycle.
  - Data presented while in_ready=0 is not captured; the source must hold it.
- FSM states IDLE, RUN, STARVED:
  - IDLE: sym_i/sym_q = 0. Move to RUN on the first sym_clk_en where occupancy >= START_LEVEL; that same sym_clk_en pops and transmits.
  - RUN: each sym_clk_en pops one entry, registers the mapped levels into sym_i/sym_q, and increments sym_cnt.
  - Empty FIFO at a sym_clk_en while in RUN:
    - go to STARVED and load sym_i/sym_q with 0;
    - pulse underflow for one sys_clk;
    - increment underflow_cnt, saturating at 16'hFFFF;
    - leave sym_cnt unchanged.
  - STARVED: behaves like IDLE (re-prime to START_LEVEL, zeros out). Additional empty sym_clk_en cycles do not re-pulse underflow.
  - active = (state==RUN).
- Latency: sym_i/sym_q update 1 sys_clk after the sym_clk_en edge that pops.
- Upsampler:
  - A 2-bit phase counter clears on sym_clk_en and increments on the other sam_clk_en.
  - At phase 0 (the sym_clk_en cycle), up_i/up_q take the newly mapped levels, registered in the same cycle as sym_i/sym_q.
  - On phases 1–3, up_i/up_q = 0.
  - All outputs hold between enables.
- Simultaneous write and pop:
  - Both take effect and occupancy is unchanged.
  - A pop from an empty FIFO concurrent with a write is an underflow; the written entry is stored, not bypassed.
- Full FIFO: in_ready=0; a pop in that cycle frees space, but in_ready rises one cycle later.
- Pointers wrap modulo FIFO_DEPTH; an occupancy counter of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- Reset asserted mid-stream: immediate return to reset values; the FIFO contents are discarded.

Test Plan:
- After reset, write 0x0,0x5,0xA,0xF, then run sym_clk_en every 4 sam_clk_en:
  - RUN entered at the first enable.
  - sym_i sequence: -65535, -21845, 21845, 65535.
  - up_i pattern per symbol: level,0,0,0.
  - sym_cnt=4.
- Write 0x6 (I=10, Q=01) with START_LEVEL reached -> sym_i=+21845, sym_q=-21845.
- Fill 8 entries with no pops -> in_ready=0 after the 8th write; a 9th write held with in_valid=1 is accepted only after the next pop, and the data order is preserved.
- Run the FIFO dry in RUN:
  - exactly one underflow pulse; underflow_cnt=1; state STARVED; sym_i=0.
  - Write 3 entries -> stays STARVED; write a 4th -> RUN at the next sym_clk_en.
- Write and pop in the same cycle at occupancy 4 -> occupancy stays 4; the popped value is the oldest entry.
- Assert reset between sym_clk_en pulses with 5 entries queued -> all outputs 0 immediately, in_ready=1; after release, 4 writes are needed to restart.
